store_align: RTL and testbench
==============================

# store_align

Store-side data path: the reverse of the immediate/load extender. It takes a 32-bit register value plus a byte address and access size, narrows and lane-shifts the data, and drives little-endian, word-aligned bus beats with byte enables to the data memory. Misaligned halfword/word stores are split into two beats by a small state machine. It sits between the core's store issue point and the data-memory write port.

## Interface
Parameters: none (bus fixed at 32-bit data, 32-bit byte address, 4 byte lanes).

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request (high exactly in IDLE)
- req_addr  in  32  byte address
- req_data  in  32  register value; low bits are used for narrow sizes
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- mem_wvalid  out  1  beat valid
- mem_wready  in  1  memory accepts beat
- mem_addr  out  32  word-aligned beat address (bits [1:0] always 00)
- mem_wdata  out  32  lane-positioned write data; disabled lanes are 0
- mem_be  out  4  byte enables; bit i covers mem_wdata[8i+7:8i]
- done  out  1  one-cycle pulse after the final beat of a store completes
- err  out  1  one-cycle pulse for an illegal-size request

## Operation
- States: IDLE, BEAT0, BEAT1. The state, all request fields and all mem_* outputs are registered.
- Accept: req_valid & req_ready at a clock edge. The block latches the address, data and size, and moves to BEAT0. For size 11 it stays in IDLE and pulses err instead.
- Definitions: o = req_addr[1:0]; A = {req_addr[31:2], 2'b00}.
- Byte: one beat. mem_addr=A, mem_be=1<<o, and data[7:0] goes to lane o.
- Half, o≤2: one beat. mem_be=0011<<o, mem_wdata=data[15:0]<<8o.
- Half, o=3: two beats.
  - Beat0: A, be=1000, lane3=data[7:0].
  - Beat1: A+4, be=0001, lane0=data[15:8].
- Word, o=0: one beat. be=1111, mem_wdata=data.
- Word, o≠0: two beats.
  - Beat0: A, be=(1111<<o)[3:0], wdata=data<<8o.
  - Beat1: A+4, be=1111>>(4−o), wdata=data>>8(4−o).
- A+4 is computed modulo 2^32, so address FFFFFFFC wraps to 00000000.
- BEAT0: hold mem_wvalid and all mem_* fields stable until mem_wready. On the handshake, go to BEAT1 if a second beat is needed, else to IDLE with done.
- BEAT1: hold until mem_wready, then go to IDLE with done.
- Reset at any time, including mid-store: immediately return to IDLE and drop mem_wvalid. The in-flight beat is abandoned and no done is produced.

## Timing
- Reset values:
  - state=IDLE, req_ready=1.
  - mem_wvalid=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - done=0, err=0.
- Accept at edge N: in cycle N+1, mem_wvalid=1 with beat0 presented and req_ready=0.
- With mem_wready tied high:
  - A one-beat store handshakes at edge N+1; done=1 and req_ready=1 in cycle N+2.
  - A two-beat store presents beat1 in N+2, handshakes at edge N+2, and has done=1 in N+3.
- mem_wready low stretches each beat by one cycle per stall cycle; outputs do not change while stalled.
- Outside a valid beat, mem_be=0 and mem_wvalid=0.
- A new request may be accepted in the same cycle that done (or err) is high. Minimum spacing is 2 cycles per single-beat store.
- err: accept of an illegal size at edge N gives err=1 in cycle N+1. No beat is issued, and req_ready stays 1.
- done and err are never high together, and each is high for exactly one cycle.

## Test plan
- **Byte store:** addr 0x00000102, data 0xAABBCCDD, size 00, wready=1 -> one beat: addr 0x100, be 0100, wdata 0x00DD0000. done follows in the next cycle.
- **Misaligned half:** addr 0x00000013, data 0x00001234, size 01 -> beat0 addr 0x10, be 1000, wdata 0x34000000; beat1 addr 0x14, be 0001, wdata 0x00000012.
- **Misaligned word with wrap:** addr 0xFFFFFFFD, data 0x11223344, size 10 -> beat0 addr 0xFFFFFFFC, be 1110, wdata 0x22334400; beat1 addr 0x00000000, be 0001, wdata 0x00000011.
- **Stall:** aligned word at 0x40 with mem_wready low for 3 cycles -> mem_wvalid, addr, be and wdata are held for 4 cycles; done follows 1 cycle after the handshake.
- **Illegal size:** size 11 -> err pulses 1 cycle, there are no mem_wvalid cycles, and a following byte store is accepted in the err cycle.
- **Reset mid-store:** assert reset during BEAT1 of a misaligned word -> mem_wvalid=0 immediately, no done, req_ready=1 after release.

Source files
------------

// File: rtl/store_align_if.sv
// Store request / data-memory write bundle for store_align.
// The slave modport is the store aligner itself; master is the side that
// issues store requests and owns the memory's write-ready.
interface store_align_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_wready,
    output req_ready, mem_wvalid, mem_addr, mem_wdata, mem_be, done, err
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_wready,
    input  req_ready, mem_wvalid, mem_addr, mem_wdata, mem_be, done, err
  );
endinterface

// File: rtl/store_align.sv
// Store-side aligner: narrows a register value to byte/half/word, shifts it
// onto little-endian byte lanes and issues one or two word-aligned write
// beats with byte enables. Misaligned stores that cross a word boundary
// are split into a second beat at the next word address (wrapping at 2^32).
module store_align (
  input  logic          clk,
  input  logic          reset,
  store_align_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        mem_wvalid_reg, mem_wvalid_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [3:0]  mem_be_reg, mem_be_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  // Second-beat fields are derived at accept time from the latched request
  // so that the BEAT0->BEAT1 transition is just a register copy.
  logic [31:0] b1_addr_reg, b1_addr_next;
  logic [31:0] b1_wdata_reg, b1_wdata_next;
  logic [3:0]  b1_be_reg, b1_be_next;

  logic [71:0] req_lanes;
  logic [31:0] req_word_addr;

  // Place the access on an 8-lane (two-word) window starting at the word
  // address: the low 4 lanes form beat 0 and the high 4 lanes form beat 1.
  // Returns {be_wide[7:0], wdata_wide[63:0]}.
  function automatic logic [71:0] lanes(input logic [1:0]  o,
                                        input logic [31:0] data,
                                        input logic [1:0]  size);
    logic [7:0]  be_base;
    logic [63:0] d_base;
    case (size)
      2'b00:   begin be_base = 8'h01; d_base = {56'd0, data[7:0]};  end
      2'b01:   begin be_base = 8'h03; d_base = {48'd0, data[15:0]}; end
      default: begin be_base = 8'h0F; d_base = {32'd0, data};       end
    endcase
    return {be_base << o, d_base << {o, 3'b000}};
  endfunction

  assign req_lanes     = lanes(bus.req_addr[1:0], bus.req_data, bus.req_size);
  assign req_word_addr = {bus.req_addr[31:2], 2'b00};

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.mem_wvalid = mem_wvalid_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.mem_be     = mem_be_reg;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;

  // State and all registered outputs; reset abandons any in-flight beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      mem_wvalid_reg <= 1'b0;
      mem_addr_reg   <= 32'd0;
      mem_wdata_reg  <= 32'd0;
      mem_be_reg     <= 4'd0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      b1_addr_reg    <= 32'd0;
      b1_wdata_reg   <= 32'd0;
      b1_be_reg      <= 4'd0;
    end else begin
      state_reg      <= state_next;
      mem_wvalid_reg <= mem_wvalid_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_be_reg     <= mem_be_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      b1_addr_reg    <= b1_addr_next;
      b1_wdata_reg   <= b1_wdata_next;
      b1_be_reg      <= b1_be_next;
    end
  end

  // Next-state and next-output logic; everything holds unless a handshake
  // or an accept moves it.
  always_comb begin
    state_next      = state_reg;
    mem_wvalid_next = mem_wvalid_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    mem_be_next     = mem_be_reg;
    done_next       = 1'b0;
    err_next        = 1'b0;
    b1_addr_next    = b1_addr_reg;
    b1_wdata_next   = b1_wdata_reg;
    b1_be_next      = b1_be_reg;

    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_size == 2'b11) begin
            err_next = 1'b1;
          end else begin
            state_next      = BEAT0;
            mem_wvalid_next = 1'b1;
            mem_addr_next   = req_word_addr;
            mem_be_next     = req_lanes[67:64];
            mem_wdata_next  = req_lanes[31:0];
            b1_addr_next    = req_word_addr + 32'd4;
            b1_be_next      = req_lanes[71:68];
            b1_wdata_next   = req_lanes[63:32];
          end
        end
      end

      BEAT0: begin
        if (bus.mem_wready) begin
          if (b1_be_reg != 4'd0) begin
            state_next     = BEAT1;
            mem_addr_next  = b1_addr_reg;
            mem_be_next    = b1_be_reg;
            mem_wdata_next = b1_wdata_reg;
          end else begin
            state_next      = IDLE;
            mem_wvalid_next = 1'b0;
            mem_be_next     = 4'd0;
            mem_wdata_next  = 32'd0;
            done_next       = 1'b1;
          end
        end
      end

      BEAT1: begin
        if (bus.mem_wready) begin
          state_next      = IDLE;
          mem_wvalid_next = 1'b0;
          mem_be_next     = 4'd0;
          mem_wdata_next  = 32'd0;
          done_next       = 1'b1;
        end
      end

      default: begin
        state_next      = IDLE;
        mem_wvalid_next = 1'b0;
        mem_be_next     = 4'd0;
        mem_wdata_next  = 32'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_store_align.sv
// Directed bench for store_align: expected beats go into a scoreboard when
// a store is driven and are checked by a monitor as each beat handshakes.
module tb_store_align;

  logic clk;
  logic reset;

  store_align_if bus ();

  store_align dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.be = be; b.data = d;
    exp_q.push_back(b);
  endtask

  // Drive one request for a single accepting edge; afterwards we are in N+1.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
    bus.req_valid = 1'b1;
    cyc();
    bus.req_valid = 1'b0;
    $display("req addr=%h data=%h size=%0d", a, d, s);
  endtask

  // Beat monitor: compare every handshaking beat with the scoreboard front.
  always @(negedge clk) begin
    beat_t b;
    if (!reset) begin
      if (bus.mem_wvalid && bus.mem_wready) begin
        $display("beat addr=%h be=%b wdata=%h", bus.mem_addr, bus.mem_be, bus.mem_wdata);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_addr", bus.mem_addr, b.addr);
          chk("beat_be", {28'd0, bus.mem_be}, {28'd0, b.be});
          chk("beat_wdata", bus.mem_wdata, b.data);
        end
      end
      if (bus.done || bus.err)
        chk("done_err_excl", {31'd0, bus.done & bus.err}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_data   = 32'd0;
    bus.req_size   = 2'b00;
    bus.mem_wready = 1'b1;
    cyc(); cyc();

    // Reset values
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_wvalid", {31'd0, bus.mem_wvalid}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    reset = 1'b0;
    cyc();

    // Byte store, one beat
    push(32'h0000_0100, 4'b0100, 32'h00DD_0000);
    send(32'h0000_0102, 32'hAABB_CCDD, 2'b00);
    chk("byte_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
    chk("byte_busy", {31'd0, bus.req_ready}, 32'd0);
    cyc();
    chk("byte_done", {31'd0, bus.done}, 32'd1);
    chk("byte_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("byte_idle_be", {28'd0, bus.mem_be}, 32'd0);
    chk("byte_idle_wvalid", {31'd0, bus.mem_wvalid}, 32'd0);
    cyc();
    chk("byte_done_pulse", {31'd0, bus.done}, 32'd0);

    // Aligned half in the upper lanes
    push(32'h0000_0020, 4'b1100, 32'h5678_0000);
    send(32'h0000_0022, 32'hFFFF_5678, 2'b01);
    cyc();
    chk("half2_done", {31'd0, bus.done}, 32'd1);
    cyc();

    // Misaligned half, two beats
    push(32'h0000_0010, 4'b1000, 32'h3400_0000);
    push(32'h0000_0014, 4'b0001, 32'h0000_0012);
    send(32'h0000_0013, 32'h0000_1234, 2'b01);
    cyc();
    chk("mhalf_beat1_valid", {31'd0, bus.mem_wvalid}, 32'd1);
    chk("mhalf_no_early_done", {31'd0, bus.done}, 32'd0);
    cyc();
    chk("mhalf_done", {31'd0, bus.done}, 32'd1);
    cyc();

    // Misaligned word with address wrap
    push(32'hFFFF_FFFC, 4'b1110, 32'h2233_4400);
    push(32'h0000_0000, 4'b0001, 32'h0000_0011);
    send(32'hFFFF_FFFD, 32'h1122_3344, 2'b10);
    cyc();
    chk("wrap_beat1_addr", bus.mem_addr, 32'h0000_0000);
    cyc();
    chk("wrap_done", {31'd0, bus.done}, 32'd1);
    cyc();

    // Stall: aligned word held for 4 cycles with wready low for 3
    bus.mem_wready = 1'b0;
    push(32'h0000_0040, 4'b1111, 32'hCAFE_F00D);
    send(32'h0000_0040, 32'hCAFE_F00D, 2'b10);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      chk("stall_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
      chk("stall_addr", bus.mem_addr, 32'h0000_0040);
      chk("stall_be", {28'd0, bus.mem_be}, 32'h0000_000F);
      chk("stall_wdata", bus.mem_wdata, 32'hCAFE_F00D);
      chk("stall_no_done", {31'd0, bus.done}, 32'd0);
    end
    cyc();
    chk("stall_hold4_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
    chk("stall_hold4_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    bus.mem_wready = 1'b1;
    cyc();
    chk("stall_done", {31'd0, bus.done}, 32'd1);
    cyc();

    // Illegal size, then a byte store accepted in the err cycle
    bus.req_addr  = 32'h0000_0200;
    bus.req_data  = 32'h1234_5678;
    bus.req_size  = 2'b11;
    bus.req_valid = 1'b1;
    cyc();
    $display("req addr=00000200 data=12345678 size=3 (illegal)");
    chk("ill_err", {31'd0, bus.err}, 32'd1);
    chk("ill_no_beat", {31'd0, bus.mem_wvalid}, 32'd0);
    chk("ill_ready", {31'd0, bus.req_ready}, 32'd1);
    push(32'h0000_0004, 4'b1000, 32'h5500_0000);
    send(32'h0000_0007, 32'h0000_0055, 2'b00);
    chk("ill_err_pulse", {31'd0, bus.err}, 32'd0);
    chk("after_ill_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
    cyc();
    chk("after_ill_done", {31'd0, bus.done}, 32'd1);
    cyc();

    // Reset during BEAT1 of a misaligned word
    push(32'h0000_0100, 4'b1100, 32'hC3D4_0000);
    send(32'h0000_0102, 32'hA1B2_C3D4, 2'b10);
    cyc();
    bus.mem_wready = 1'b0;
    chk("rstmid_b1_addr", bus.mem_addr, 32'h0000_0104);
    chk("rstmid_b1_be", {28'd0, bus.mem_be}, 32'h0000_0003);
    chk("rstmid_b1_wdata", bus.mem_wdata, 32'h0000_A1B2);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_wvalid", {31'd0, bus.mem_wvalid}, 32'd0);
    chk("rstmid_no_done", {31'd0, bus.done}, 32'd0);
    cyc();
    reset = 1'b0;
    bus.mem_wready = 1'b1;
    cyc();
    chk("rstmid_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstmid_no_done2", {31'd0, bus.done}, 32'd0);
    chk("rstmid_idle_wvalid", {31'd0, bus.mem_wvalid}, 32'd0);
    cyc();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
